// File: rtl/sa_nxn_engine.sv
// sa_nxn_engine: output-stationary NxN systolic matrix multiplier.
// A k x k job (k = 1..N) is streamed in over k handshaked beats. Each input
// lane is skewed by its own index so that PE(i,j) sees beat t at step t+i+j.
// After a 2k-2 step drain, the k*k results are read out in row-major order
// on a saturating valid/ready port.

// One processing element: a multiply-accumulate that advances with the array.
module sa_pe #(
    parameter int DW   = 8,
    parameter int ACCW = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            adv,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    output logic [ACCW-1:0] acc_o
);
    logic [ACCW-1:0] acc_q;
    logic [2*DW-1:0] prod;

    assign prod  = a_i * b_i;
    assign acc_o = acc_q;

    // accumulate one product per array step; cleared at job start
    always_ff @(posedge clk) begin
        if (!rst || clr) acc_q <= '0;
        else if (adv)    acc_q <= acc_q + ACCW'(prod);
    end
endmodule

module sa_nxn_engine #(
    parameter int DW   = 8,
    parameter int N    = 3,
    parameter int ACCW = 18,
    parameter int OW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      size,
    input  logic [N*DW-1:0] a_in,
    input  logic [N*DW-1:0] b_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [OW-1:0]   out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;
    localparam int         IW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] KMAX    = 4'(N);

    logic [1:0]    state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [IW-1:0] r_q, r_d, c_q, c_d;
    logic          done_q, done_d, err_q, err_d;
    logic          size_ok, clr, xfer, adv, rd;

    assign size_ok   = (size != 4'd0) && (size <= KMAX);
    assign clr       = (state_q == S_IDLE) && start && size_ok;
    assign in_ready  = (state_q == S_LOAD);
    assign xfer      = in_ready && in_valid;
    // the whole array, skew lines included, only moves on a beat or in drain
    assign adv       = xfer || (state_q == S_DRAIN);
    assign out_valid = (state_q == S_OUT);
    assign rd        = out_valid && out_ready;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;

    // job sequencing: accept, load k beats, drain 2k-2 steps, read k*k results
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        c_d     = c_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (size_ok) begin
                        k_d     = size;
                        cnt_d   = '0;
                        r_d     = '0;
                        c_d     = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    if (cnt_q == {1'b0, k_q} - 5'd1) begin
                        cnt_d   = '0;
                        state_d = (k_q == 4'd1) ? S_OUT : S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == {k_q, 1'b0} - 5'd3) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_OUT: begin
                if (rd) begin
                    if (4'(c_q) == k_q - 4'd1) begin
                        c_d = '0;
                        if (4'(r_q) == k_q - 4'd1) begin
                            r_d     = '0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // control registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            c_q     <= c_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // operand seen by each PE and its accumulator
    logic [DW-1:0]   a_op [N][N];
    logic [DW-1:0]   b_op [N][N];
    logic [ACCW-1:0] acc  [N][N];

    // lane i feeds A row i and B column i; unused lanes and drain steps inject 0
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic          lane_on;
        logic [DW-1:0] a_lane, b_lane;
        assign lane_on = (state_q == S_LOAD) && (4'(i) < k_q);
        assign a_lane  = lane_on ? a_in[i*DW +: DW] : '0;
        assign b_lane  = lane_on ? b_in[i*DW +: DW] : '0;
        if (i == 0) begin : g_direct
            assign a_op[0][0] = a_lane;
            assign b_op[0][0] = b_lane;
        end else begin : g_skew
            logic [DW-1:0] ska_q [i];
            logic [DW-1:0] skb_q [i];
            // i-step delay line on both operands of this lane
            always_ff @(posedge clk) begin
                if (!rst || clr) begin
                    for (int d = 0; d < i; d++) begin
                        ska_q[d] <= '0;
                        skb_q[d] <= '0;
                    end
                end else if (adv) begin
                    ska_q[0] <= a_lane;
                    skb_q[0] <= b_lane;
                    for (int d = 1; d < i; d++) begin
                        ska_q[d] <= ska_q[d-1];
                        skb_q[d] <= skb_q[d-1];
                    end
                end
            end
            assign a_op[i][0] = ska_q[i-1];
            assign b_op[0][i] = skb_q[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j > 0) begin : g_fa
                logic [DW-1:0] a_q;
                // pass a one column to the right per step
                always_ff @(posedge clk) begin
                    if (!rst || clr) a_q <= '0;
                    else if (adv)    a_q <= a_op[i][j-1];
                end
                assign a_op[i][j] = a_q;
            end
            if (i > 0) begin : g_fb
                logic [DW-1:0] b_q;
                // pass b one row down per step
                always_ff @(posedge clk) begin
                    if (!rst || clr) b_q <= '0;
                    else if (adv)    b_q <= b_op[i-1][j];
                end
                assign b_op[i][j] = b_q;
            end
            sa_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .adv   (adv),
                .a_i   (a_op[i][j]),
                .b_i   (b_op[i][j]),
                .acc_o (acc[i][j])
            );
        end
    end

    // readout: saturate the selected accumulator, zero when not presenting
    logic [ACCW-1:0] acc_sel;
    logic [OW-1:0]   sat;
    assign acc_sel = acc[r_q][c_q];
    assign sat     = (|acc_sel[ACCW-1:OW]) ? '1 : acc_sel[OW-1:0];
    assign out     = out_valid ? sat : '0;
endmodule

// File: tb/tb_sa_nxn_engine.sv
// Scoreboard bench for sa_nxn_engine: expected C = A*B (saturated) is queued
// at job start and popped as each result is accepted on the output port.
module tb_sa_nxn_engine;
    localparam int DW = 8, N = 3, ACCW = 18, OW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [3:0]      size = '0;
    logic [N*DW-1:0] a_in = '0, b_in = '0;
    logic            in_valid = 1'b0, in_ready;
    logic [OW-1:0]   out;
    logic            out_valid, out_ready = 1'b0;
    logic            busy, done, err;

    always #5 clk = ~clk;

    sa_nxn_engine #(.DW(DW), .N(N), .ACCW(ACCW), .OW(OW)) dut (
        .clk(clk), .rst(rst), .start(start), .size(size),
        .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .err(err)
    );

    int total = 0, bad = 0;
    int exp_q[$];
    int A[N][N], B[N][N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic push_exp(input int k);
        int s;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++) begin
                s = 0;
                for (int t = 0; t < k; t++) s += A[r][t] * B[t][c];
                exp_q.push_back(s > 255 ? 255 : s);
            end
    endtask

    task automatic drive(input int t, input int k, input bit real_beat);
        for (int i = 0; i < N; i++) begin
            if (real_beat && i < k) begin
                a_in[i*DW +: DW] = DW'(A[i][t]);
                b_in[i*DW +: DW] = DW'(B[t][i]);
            end else begin
                a_in[i*DW +: DW] = DW'($urandom_range(0, 255));
                b_in[i*DW +: DW] = DW'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic run_job(input int k, input int gap, input logic [3:0] orpat, input bit lat);
        int t, gapc, ocyc, first_ov, done_cyc;
        bit held;
        logic [OW-1:0] hold_v;
        t = 0; gapc = 0; ocyc = 0; first_ov = -1; done_cyc = -1; held = 0; hold_v = '0;
        push_exp(k);
        @(negedge clk);
        start = 1'b1; size = 4'(k); in_valid = 1'b0;
        for (int cyc = 1; cyc < 300; cyc++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1)); size = 4'd1;
            if (cyc == 1) chk("busy_run", busy, 1);
            if (done) begin done_cyc = cyc; break; end
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_out", out, hold_v);
                held = 0;
            end
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                out_ready = orpat[ocyc % 4];
                ocyc++;
                if (out_ready) begin
                    if (exp_q.size() == 0) chk("extra_out", exp_q.size(), 1);
                    else chk("out", out, exp_q.pop_front());
                end else begin
                    held = 1; hold_v = out;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            if (t < k && gapc == 0) begin
                in_valid = 1'b1;
                drive(t, k, 1'b1);
                if (in_ready) begin t++; gapc = gap; end
            end else if (t < k) begin
                in_valid = 1'b0;
                drive(0, k, 1'b0);
                gapc--;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                drive(0, k, 1'b0);
            end
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (done_cyc < 0) chk("done_timeout", done_cyc, 0);
        else begin
            chk("busy_end", busy, 0);
            chk("ov_end", out_valid, 0);
            chk("q_empty", exp_q.size(), 0);
            if (lat) begin
                chk("first_ov_cyc", first_ov, 3*k - 1);
                chk("done_cyc", done_cyc, 3*k - 1 + k*k);
            end
            @(negedge clk);
            chk("done_pulse", done, 0);
        end
        exp_q.delete();
    endtask

    task automatic set_2x2();
        A = '{'{1, 2, 0}, '{3, 4, 0}, '{0, 0, 0}};
        B = '{'{5, 6, 0}, '{7, 8, 0}, '{0, 0, 0}};
    endtask

    task automatic illegal(input logic [3:0] sz);
        @(negedge clk);
        start = 1'b1; size = sz;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_in_ready", in_ready, 0);
        @(negedge clk);
        chk("err_clear", err, 0);
        chk("err_busy2", busy, 0);
    endtask

    initial begin
        bit seen;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out", out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;

        // 2x2 basic with latency
        set_2x2();
        run_job(2, 0, 4'b1111, 1'b1);

        // 3x3 identity * B, latency 8 / 17
        A = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
        B = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
        run_job(3, 0, 4'b1111, 1'b1);

        // saturation
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin A[i][j] = 255; B[i][j] = 255; end
        run_job(3, 0, 4'b1111, 1'b1);

        // scalar job, upper lanes carry garbage
        A = '{'{12, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        B = '{'{10, 0, 0}, '{0, 0, 0}, '{0, 0, 0}};
        run_job(1, 0, 4'b1111, 1'b0);

        // input stalls and output backpressure 1,0,0,1
        set_2x2();
        run_job(2, 3, 4'b1001, 1'b0);

        // illegal sizes, then a normal job
        illegal(4'd0);
        illegal(4'd4);
        set_2x2();
        run_job(2, 0, 4'b1111, 1'b1);

        // reset in the middle of LOAD
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin A[i][j] = 7; B[i][j] = 9; end
        @(negedge clk);
        start = 1'b1; size = 4'd2;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; drive(0, 2, 1'b1);
        @(negedge clk);
        chk("mid_in_ready", in_ready, 1);
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out", out, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen |= done;
        end
        chk("mid_no_done", seen, 0);
        set_2x2();
        run_job(2, 0, 4'b1111, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sa_nxn_engine.md
Name: sa_nxn_engine

Overview:
Parametrised successor to the fixed 2x2/3x3 systolic compute paths. It is a single output-stationary NxN systolic array that multiplies two k x k unsigned matrices, where k (1..N) is selected per job at run time. It adds a start/busy/done control, valid/ready streaming with stall support, internal input skewing, and a saturating, handshaked serial result readout. It sits behind the operand demux in the computation datapath and drives one leg of the output mux.

Parameters:
DW, 8, operand width (unsigned)
N, 3, physical array dimension (max k)
ACCW, 18, accumulator width per PE (must be >= 2*DW + clog2(N))
OW, 8, result output width (saturated)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
start  input  1  job request, sampled only in IDLE
size  input  4  k for the job, legal values 1..N
a_in  input  N*DW  lane i (bits i*DW+:DW) = A[i][t] for beat t
b_in  input  N*DW  lane j = B[t][j] for beat t
in_valid  input  1  operand beat valid
in_ready  output  1  engine accepts a beat
out  output  OW  result element, row-major order
out_valid  output  1  out holds a valid result
out_ready  input  1  consumer accepts out
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last result is accepted
err  output  1  one-cycle pulse when start is issued with an illegal size

Behaviour:
- Reset (rst==0 at a clock edge): state goes to IDLE; all PE accumulators, skew registers, counters and k clear to 0; in_ready, out, out_valid, busy, done and err all go to 0. Reset applied in any state aborts the job and produces no done.
- FSM states: IDLE, LOAD, DRAIN, OUT.
- IDLE:
  - start=1 with 1<=size<=N: latch k=size, clear all accumulators, go to LOAD; busy=1 from the next cycle.
  - start=1 with size=0 or size>N: err=1 for one cycle; stay in IDLE.
- LOAD:
  - in_ready=1. A beat transfers when in_valid & in_ready.
  - Each transfer advances the array one step. Lanes >= k are forced to 0.
  - No transfer means the entire array, including the skew pipes, holds its state (global clock-enable).
  - After k transfers: go to DRAIN, or go directly to OUT if k==1.
- Skew:
  - Row i of A is delayed by i steps; column j of B is delayed by j steps.
  - PE(i,j) computes acc += a*b on its operands and forwards a to the right and b downward, one step per advance.
  - PE(i,j) sees beat t at step t+i+j.
- DRAIN:
  - in_ready=0. The array advances every cycle with zero operands for exactly 2k-2 cycles, then goes to OUT.
- OUT:
  - Present C[r][c] for r,c < k in row-major order.
  - out = acc if acc <= 2^OW-1, else all ones.
  - out_valid stays high and out stays stable until out_ready is sampled high.
  - After the k*k-th transfer: out_valid=0, done=1 for one cycle, state goes to IDLE, busy=0.
- Accumulators never wrap for legal N (ACCW rule). PEs outside the k x k region accumulate zeros only.
- start is ignored while busy. in_valid is ignored outside LOAD. out_ready is ignored outside OUT.
- Latency with in_valid held at 1 and out_ready held at 1:
  - start at cycle 0; in_ready=1 in cycles 1..k; DRAIN for 2k-2 cycles.
  - First out_valid at cycle 3k-1 (k>=2).
  - done at cycle 3k-1+k*k.

Test Plan:
- 2x2: start with size=2. Beat0 a=(1,3), b=(5,6); beat1 a=(2,4), b=(7,8). Required out sequence: 19, 22, 43, 50; then done pulses once; busy falls.
- 3x3: A=identity, B=[[1..3],[4..6],[7..9]]. Required out sequence: 1..9 in row-major order. Check first out_valid at cycle 8 and done at cycle 17 with no stalls.
- Saturation and scalar case:
  - k=3 with all operands 255 -> all nine outputs are 255.
  - k=1 with a=12, b=10 -> single output 120.
- Backpressure and stall: k=2 as in the first test, with in_valid low for 3 cycles between beats and out_ready toggling 1,0,0,1 -> results are identical (19, 22, 43, 50), no result is duplicated or dropped, and out is stable while stalled.
- Illegal size: start with size=0, then size=4 -> err pulses each time, busy stays 0, in_ready stays 0. A following start with size=2 runs normally.
- Reset mid-job: rst=0 during LOAD after one beat -> all outputs 0 next cycle and no done. A new k=2 job then produces 19, 22, 43, 50 (no stale accumulation).
